// File: rtl/s74194_pkg.sv
// Shared mode encodings for the s74194 universal shift register.
package s74194_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

endpackage

// File: rtl/s74194.sv
// 74194-style universal shift register: hold / shift right / shift left / load.
// Optional circular rotate on shifts when S74194_ROTATE_EN is defined (adds port rot).
module s74194
  import s74194_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] pin,
`ifdef S74194_ROTATE_EN
  input  logic             rot,
`endif
  output logic             sout,
  output logic [WIDTH-1:0] pout
);

  logic [WIDTH-1:0] pout_next;
  logic             sout_next;
  logic             shr_in;
  logic             shl_in;

`ifdef S74194_ROTATE_EN
  assign shr_in = rot ? pout[0]       : sin;
  assign shl_in = rot ? pout[WIDTH-1] : sin;
`else
  assign shr_in = sin;
  assign shl_in = sin;
`endif

  always_comb begin
    pout_next = pout;
    sout_next = sout;
    case (mode_e'(mode))
      MODE_HOLD: ;
      MODE_SHR: begin
        pout_next = {shr_in, pout[WIDTH-1:1]};
        sout_next = pout[0];
      end
      MODE_SHL: begin
        pout_next = {pout[WIDTH-2:0], shl_in};
        sout_next = pout[WIDTH-1];
      end
      MODE_LOAD: pout_next = pin;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pout <= '0;
      sout <= 1'b0;
    end else begin
      pout <= pout_next;
      sout <= sout_next;
    end
  end

endmodule

// File: tb/tb_s74194.sv
// Directed self-checking bench for s74194 (WIDTH=8).
module tb_s74194;

  logic       clk = 1'b0;
  logic       rst;
  logic       sin;
  logic [1:0] mode;
  logic [7:0] pin;
`ifdef S74194_ROTATE_EN
  logic       rot;
`endif
  logic       sout;
  logic [7:0] pout;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  s74194 #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .sin  (sin),
    .mode (mode),
    .pin  (pin),
`ifdef S74194_ROTATE_EN
    .rot  (rot),
`endif
    .sout (sout),
    .pout (pout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] exp_p, input logic exp_s);
    n_tests++;
    if (pout !== exp_p) begin
      n_fail++;
      $display("FAIL %s pout: got %h expected %h", name, pout, exp_p);
    end
    n_tests++;
    if (sout !== exp_s) begin
      n_fail++;
      $display("FAIL %s sout: got %b expected %b", name, sout, exp_s);
    end
  endtask

  task automatic load(input logic [7:0] v);
    rst = 1'b1; mode = 2'b11; pin = v; sin = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b0; mode = 2'b11; pin = 8'hFF; sin = 1'b1;
    step();
    chk("reset_beats_load", 8'h00, 1'b0);
  endtask

  task automatic test_load();
    load(8'h1A);
    chk("load_1a", 8'h1A, 1'b0);
  endtask

  task automatic test_shift_right();
    mode = 2'b01; sin = 1'b1; pin = 8'h00;
    step();
    chk("shr_sin1", 8'h8D, 1'b0);
    sin = 1'b0;
    step();
    chk("shr_sin0", 8'h46, 1'b1);
  endtask

  task automatic test_shift_left();
    load(8'h8D);
    mode = 2'b10; sin = 1'b0;
    step();
    chk("shl_sin0", 8'h1A, 1'b1);
    sin = 1'b1;
    for (int i = 0; i < 8; i++) step();
    chk("shl_fill_ones", 8'hFF, 1'b0);
  endtask

  task automatic test_hold();
    load(8'h79);
    mode = 2'b01; sin = 1'b0;
    step();
    chk("hold_setup", 8'h3C, 1'b1);
    mode = 2'b00;
    for (int i = 0; i < 4; i++) begin
      sin = ~sin;
      pin = ~pin;
      step();
      chk("hold", 8'h3C, 1'b1);
    end
  endtask

  task automatic test_mid_reset();
    load(8'hA5);
    mode = 2'b01; sin = 1'b1;
    step();
    chk("pre_reset_shr", 8'hD2, 1'b1);
    rst = 1'b0;
    step();
    chk("mid_reset", 8'h00, 1'b0);
    rst = 1'b1; mode = 2'b10; sin = 1'b1;
    step();
    chk("resume_shl", 8'h01, 1'b0);
  endtask

`ifdef S74194_ROTATE_EN
  task automatic test_rotate();
    rot = 1'b0;
    load(8'h81);
    mode = 2'b01; rot = 1'b1; sin = 1'b0;
    step();
    chk("rot_right", 8'hC0, 1'b1);
    rot = 1'b0;
    load(8'h81);
    mode = 2'b10; rot = 1'b1; sin = 1'b0;
    step();
    chk("rot_left", 8'h03, 1'b1);
    rot = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b0; sin = 1'b0; mode = 2'b00; pin = 8'h00;
`ifdef S74194_ROTATE_EN
    rot = 1'b0;
`endif
    #2;
    test_reset();
    test_load();
    test_shift_right();
    test_shift_left();
    test_hold();
    test_mid_reset();
`ifdef S74194_ROTATE_EN
    test_rotate();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/s74194.md
Name: s74194

Overview:
Parameterised bidirectional universal shift register modelled on the 74194 (hold / shift right / shift left / parallel load), default 8 bits. Used as a general-purpose serial/parallel conversion and data-alignment element in the datapath. Fully synchronous: one clock domain, all state updates on the rising edge.

Parameters:
WIDTH, 8, register width in bits (≥2).

Ports:
clk   input   1      rising-edge clock
rst   input   1      synchronous reset, active-low (sampled on rising clk edge; 0 = reset)
sin   input   1      serial data input, used by both shift directions
mode  input   2      operation select (see Behaviour)
pin   input   WIDTH  parallel load data
sout  output  1      registered serial output: last bit shifted out
pout  output  WIDTH  registered parallel register contents

Behaviour:
- All outputs are registers; no combinational path from inputs to outputs.
- Reset: when rst==0 at a rising edge, pout <= 0 and sout <= 0. Reset has priority over every mode.
- Mode encoding, evaluated each rising edge when rst==1:
  - 2'b00 HOLD: pout and sout unchanged.
  - 2'b01 SHIFT RIGHT (toward LSB): pout <= {sin, pout[WIDTH-1:1]}; sout <= old pout[0].
  - 2'b10 SHIFT LEFT (toward MSB): pout <= {pout[WIDTH-2:0], sin}; sout <= old pout[WIDTH-1].
  - 2'b11 PARALLEL LOAD: pout <= pin; sout unchanged.
- Latency: one clock from sampled inputs to pout/sout.
- Inputs are sampled only at the rising edge; changes between edges have no effect.
- X/Z on mode is not supported; any non-listed value is impossible with 2 bits.
- Reset asserted mid-sequence clears the register immediately at that edge, regardless of mode, sin or pin; operation resumes at the first edge with rst==1.
- Repeated shifts in one direction with constant sin fill the register with sin after WIDTH edges; no wrap-around unless the optional feature is enabled.

Optional Feature:
Macro S74194_ROTATE_EN.
- Defined: adds input port rot (1 bit). When rot==1 in mode 01, the bit entering the MSB is old pout[0]; in mode 10, the bit entering the LSB is old pout[WIDTH-1] (circular rotate). sout is updated as in non-rotate shifting. rot is ignored in modes 00 and 11 and during reset.
- Not defined: no rot port; shifts always take sin.

Decomposition:
- Shared package s74194_pkg: 2-bit mode constants MODE_HOLD=2'b00, MODE_SHR=2'b01, MODE_SHL=2'b10, MODE_LOAD=2'b11 and a mode typedef.
- No sub-module; a single flat register with a next-state case statement is natural.

Test Plan:
- Reset: rst=0 for one edge with mode=11, pin=8'hFF -> pout=8'h00, sout=0 (reset beats load).
- Load: rst=1, mode=11, pin=8'h1A -> after one edge pout=8'h1A, sout=0 (unchanged).
- Shift right: from pout=8'h1A, mode=01, sin=1 -> pout=8'h8D, sout=0; the next edge with sin=0 -> pout=8'h46, sout=1.
- Shift left: from pout=8'h8D, mode=10, sin=0 -> pout=8'h1A, sout=1; 8 further edges with sin=1 -> pout=8'hFF.
- Hold: pout=8'h3C, mode=00, toggle sin and pin every edge for 4 edges -> pout stays 8'h3C, sout unchanged.
- Rotate (S74194_ROTATE_EN): pout=8'h81, mode=01, rot=1, sin=0 -> pout=8'hC0, sout=1; mode=10, rot=1 from 8'h81 -> pout=8'h03, sout=1.
